voice_mixer: RTL and testbench

VOICE_MIXER -- requirements
Module: voice_mixer

---
 rtl/synth_pkg.sv | 21 ++
 rtl/lrck_edge_sync.sv | 38 +++
 rtl/voice_mixer.sv | 159 +++++++++++++++
 tb/tb_voice_mixer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants and types for the voice mixer.
//   NUM_VOICES  : default number of summed voices
//   SAMPLE_W    : default sample width (two's complement)
//   GAIN_UNITY  : Q1.7 gain code for 1.0
//   ACC_W       : accumulator width that cannot overflow for the defaults
//   mix_state_t : mixer FSM states
package synth_pkg;

  localparam int NUM_VOICES = 8;
  localparam int SAMPLE_W   = 16;
  localparam logic [7:0] GAIN_UNITY = 8'h80;
  localparam int ACC_W      = SAMPLE_W + $clog2(NUM_VOICES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCALE = 2'd2,
    ST_SAT   = 2'd3
  } mix_state_t;

endpackage

// File: rtl/lrck_edge_sync.sv
// Brings the raw DAC LR clock into the Clk domain and flags its rising edges.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   lrck  : raw LR clock, asynchronous to clk
//   rise  : one-cycle pulse per detected rising edge of lrck
module lrck_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic lrck,
  output logic rise
);

  logic sync1_reg;
  logic sync2_reg;
  logic sync3_reg;
  // Tracks which pipeline stages hold a genuine sample of lrck since reset.
  // Without it, lrck already high at reset release would look like a
  // 0->1 transition against the cleared flops.
  logic [2:0] valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      sync3_reg <= 1'b0;
      valid_reg <= 3'b000;
    end else begin
      sync1_reg <= lrck;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
      valid_reg <= {valid_reg[1:0], 1'b1};
    end
  end

  // sync3 must hold a real low sample before a rise can be reported.
  assign rise = sync2_reg & ~sync3_reg & valid_reg[2];

endmodule

// File: rtl/voice_mixer.sv
// Sums NUM_VOICES signed voice samples once per LR clock rising edge,
// applies a Q1.7 master gain and saturates to SAMPLE_W bits.
//   Clk        : system clock
//   Reset      : asynchronous active-high reset
//   lrck       : raw LR clock; each rising edge requests one mixed sample
//   voice_in   : packed voice samples, index 0 = voice0
//   voice_mask : per-voice enable
//   gain       : unsigned Q1.7 master gain (8'h80 = unity)
//   clip_clr   : synchronous clear of clip and overrun
//   mix_out    : saturated mixed sample, held between updates
//   out_valid  : one-cycle pulse when mix_out updates
//   clip       : sticky, set when a sample saturates
//   overrun    : sticky, set when an lrck edge arrives while busy
module voice_mixer
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = synth_pkg::NUM_VOICES,
  parameter int SAMPLE_W   = synth_pkg::SAMPLE_W
) (
  input  logic                                 Clk,
  input  logic                                 Reset,
  input  logic                                 lrck,
  input  logic [NUM_VOICES-1:0][SAMPLE_W-1:0]  voice_in,
  input  logic [NUM_VOICES-1:0]                voice_mask,
  input  logic [7:0]                           gain,
  input  logic                                 clip_clr,
  output logic [SAMPLE_W-1:0]                  mix_out,
  output logic                                 out_valid,
  output logic                                 clip,
  output logic                                 overrun
);

  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int MIX_W  = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int PROD_W = MIX_W + 9;
  localparam int SHR_W  = PROD_W - 7;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic signed [SHR_W-1:0] SAT_MAX =
    {{(SHR_W - SAMPLE_W + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
  localparam logic signed [SHR_W-1:0] SAT_MIN =
    {{(SHR_W - SAMPLE_W + 1){1'b1}}, {(SAMPLE_W - 1){1'b0}}};

  logic rise;

  lrck_edge_sync u_lrck_edge_sync (
    .clk  (Clk),
    .rst  (Reset),
    .lrck (lrck),
    .rise (rise)
  );

  // Masking is applied before capture, so a masked voice is held as zero.
  logic [NUM_VOICES-1:0][SAMPLE_W-1:0] voice_masked;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_mask
      assign voice_masked[gi] = voice_mask[gi] ? voice_in[gi] : '0;
    end
  endgenerate

  mix_state_t                          state_reg;
  logic [NUM_VOICES-1:0][SAMPLE_W-1:0] voice_reg;
  logic [7:0]                          gain_reg;
  logic [IDX_W-1:0]                    idx_reg;
  logic signed [MIX_W-1:0]             acc_reg;
  logic signed [PROD_W-1:0]            prod_reg;
  logic [SAMPLE_W-1:0]                 mix_reg;
  logic                                valid_reg;
  logic                                clip_reg;
  logic                                overrun_reg;

  logic signed [SAMPLE_W-1:0] cur_voice;
  logic signed [SHR_W-1:0]    shifted;
  logic [SAMPLE_W-1:0]        sat_value;
  logic                       sat_hit;

  assign cur_voice = $signed(voice_reg[idx_reg]);

  // Dropping the low 7 bits of a two's-complement value is an arithmetic
  // shift that rounds toward negative infinity.
  assign shifted = prod_reg[PROD_W-1:7];

  always_comb begin
    sat_value = shifted[SAMPLE_W-1:0];
    sat_hit   = 1'b0;
    if (shifted > SAT_MAX) begin
      sat_value = SAT_MAX[SAMPLE_W-1:0];
      sat_hit   = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat_value = SAT_MIN[SAMPLE_W-1:0];
      sat_hit   = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg   <= ST_IDLE;
      voice_reg   <= '0;
      gain_reg    <= '0;
      idx_reg     <= '0;
      acc_reg     <= '0;
      prod_reg    <= '0;
      mix_reg     <= '0;
      valid_reg   <= 1'b0;
      clip_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;

      // Clear first so that a set in the same cycle takes precedence.
      if (clip_clr) begin
        clip_reg    <= 1'b0;
        overrun_reg <= 1'b0;
      end
      if (rise && (state_reg != ST_IDLE)) begin
        overrun_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (rise) begin
            voice_reg <= voice_masked;
            gain_reg  <= gain;
            acc_reg   <= '0;
            idx_reg   <= '0;
            state_reg <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          acc_reg <= acc_reg + MIX_W'(cur_voice);
          idx_reg <= idx_reg + 1'b1;
          if (idx_reg == LAST_IDX) begin
            state_reg <= ST_SCALE;
          end
        end
        ST_SCALE: begin
          prod_reg  <= acc_reg * $signed({1'b0, gain_reg});
          state_reg <= ST_SAT;
        end
        ST_SAT: begin
          mix_reg   <= sat_value;
          valid_reg <= 1'b1;
          if (sat_hit) begin
            clip_reg <= 1'b1;
          end
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign mix_out   = mix_reg;
  assign out_valid = valid_reg;
  assign clip      = clip_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: each lrck request is timed edge by edge,
// with hand-computed expected mix values, flags and pulse timing.
module tb_voice_mixer;

  logic             Clk;
  logic             Reset;
  logic             lrck;
  logic [7:0][15:0] voice_in;
  logic [7:0]       voice_mask;
  logic [7:0]       gain;
  logic             clip_clr;
  logic [15:0]      mix_out;
  logic             out_valid;
  logic             clip;
  logic             overrun;

  int vectors;
  int miscompares;

  voice_mixer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .lrck       (lrck),
    .voice_in   (voice_in),
    .voice_mask (voice_mask),
    .gain       (gain),
    .clip_clr   (clip_clr),
    .mix_out    (mix_out),
    .out_valid  (out_valid),
    .clip       (clip),
    .overrun    (overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < 8; i++) voice_in[i] = v;
  endtask

  // One lrck request: lrck goes high just before edge 0, the bench watches
  // edges 0..18 and checks a single out_valid pulse at edge 12.
  task automatic run_sample(input string tag, input logic [7:0] m, input logic [7:0] g,
                            input logic [15:0] exp_mix, input logic exp_clip,
                            input bit perturb);
    int pulses;
    int seen_edge;
    pulses = 0;
    seen_edge = -1;
    voice_mask = m;
    gain = g;
    @(negedge Clk);
    lrck = 1'b1;
    for (int e = 0; e <= 18; e++) begin
      @(posedge Clk);
      #1;
      if (out_valid) begin
        pulses++;
        if (seen_edge < 0) seen_edge = e;
      end
      if (e == 3) lrck = 1'b0;
      if (perturb && e == 4) begin
        set_all(16'h7FFF);
        voice_mask = 8'hFF;
        gain = 8'hFF;
      end
    end
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_edge"}, seen_edge, 12);
    check({tag, "_mix"}, mix_out, exp_mix);
    check({tag, "_clip"}, clip, exp_clip);
    $display("sample %s: mix_out=%0h clip=%0b overrun=%0b", tag, mix_out, clip, overrun);
  endtask

  task automatic pulse_clip_clr();
    @(negedge Clk);
    clip_clr = 1'b1;
    @(negedge Clk);
    clip_clr = 1'b0;
  endtask

  initial begin
    int pulses;
    vectors = 0;
    miscompares = 0;
    Reset = 1'b1;
    lrck = 1'b0;
    voice_in = '0;
    voice_mask = 8'h00;
    gain = 8'h00;
    clip_clr = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_mix", mix_out, 16'h0000);
    check("rst_valid", out_valid, 1'b0);
    check("rst_clip", clip, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (5) @(posedge Clk);

    // 8 x 0x0400 at unity = 0x2000
    set_all(16'h0400);
    run_sample("unity", 8'hFF, 8'h80, 16'h2000, 1'b0, 1'b0);
    check("unity_overrun", overrun, 1'b0);

    // -3 * 0.5 = -1.5 floors to -2
    set_all(16'h0000);
    voice_in[0] = 16'hFFFD;
    run_sample("floor", 8'hFF, 8'h40, 16'hFFFE, 1'b0, 1'b0);

    // 100 * 0.5 = 50
    voice_in[0] = 16'd100;
    run_sample("half", 8'hFF, 8'h40, 16'd50, 1'b0, 1'b0);

    // only voice0 enabled: 1000
    set_all(16'd1000);
    run_sample("mask", 8'h01, 8'h80, 16'd1000, 1'b0, 1'b0);

    // 1000 * 255/128 = 1992.19 -> 1992; inputs scrambled after capture
    set_all(16'h0000);
    voice_in[0] = 16'd1000;
    run_sample("hold", 8'hFF, 8'hFF, 16'd1992, 1'b0, 1'b1);

    // zero gain never clips
    set_all(16'h1000);
    run_sample("gain0", 8'hFF, 8'h00, 16'h0000, 1'b0, 1'b0);

    // 8 x 0x1000 = 0x8000 saturates positive
    set_all(16'h1000);
    run_sample("satpos", 8'hFF, 8'h80, 16'h7FFF, 1'b1, 1'b0);
    pulse_clip_clr();
    #1;
    check("clr_clip", clip, 1'b0);

    // 8 x -20000 = -160000 saturates negative
    set_all(16'hB1E0);
    run_sample("satneg", 8'hFF, 8'h80, 16'h8000, 1'b1, 1'b0);

    // second lrck rise four cycles after the first is dropped
    set_all(16'h0400);
    voice_mask = 8'hFF;
    gain = 8'h80;
    pulses = 0;
    @(negedge Clk);
    lrck = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      @(posedge Clk);
      #1;
      if (out_valid) pulses++;
      if (e == 1) lrck = 1'b0;
      if (e == 3) lrck = 1'b1;
      if (e == 6) lrck = 1'b0;
    end
    check("ovr_pulses", pulses, 1);
    check("ovr_mix", mix_out, 16'h2000);
    check("ovr_flag", overrun, 1'b1);
    $display("overrun run: mix_out=%0h overrun=%0b", mix_out, overrun);
    pulse_clip_clr();
    #1;
    check("ovr_clr", overrun, 1'b0);
    check("ovr_clr_clip", clip, 1'b0);
    repeat (4) @(posedge Clk);

    // leave clip set so the abort clearly resets it
    set_all(16'h1000);
    run_sample("preabort", 8'hFF, 8'h80, 16'h7FFF, 1'b1, 1'b0);

    // Reset in the middle of ACCUM aborts the sample
    set_all(16'h0400);
    @(negedge Clk);
    lrck = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      @(posedge Clk);
      #1;
      if (e == 3) lrck = 1'b0;
    end
    Reset = 1'b1;
    #1;
    check("abort_mix", mix_out, 16'h0000);
    check("abort_valid", out_valid, 1'b0);
    check("abort_clip", clip, 1'b0);
    check("abort_overrun", overrun, 1'b0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    pulses = 0;
    for (int e = 0; e < 16; e++) begin
      @(posedge Clk);
      #1;
      if (out_valid) pulses++;
    end
    check("abort_nopulse", pulses, 0);
    run_sample("after_abort", 8'hFF, 8'h80, 16'h2000, 1'b0, 1'b0);

    // lrck already high when Reset releases: no sample until a new edge
    @(negedge Clk);
    Reset = 1'b1;
    lrck = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    pulses = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge Clk);
      #1;
      if (out_valid) pulses++;
    end
    check("highrel_nopulse", pulses, 0);
    lrck = 1'b0;
    repeat (4) @(posedge Clk);
    set_all(16'd1000);
    run_sample("highrel_next", 8'h01, 8'h80, 16'd1000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
